cpu_rv32_mc: RTL and testbench
==============================

# cpu_rv32_mc

Parametrised multicycle RV32I-subset core, successor to the fixed-PC fetch-only sequencer. It fetches and decodes instructions, and executes them against a 32×32 register file. It talks to a single-port synchronous word memory with configurable read latency and halts on EBREAK. It sits between the simulator's memory model and the top-level run/halt control.

## Interface
- ADDR_W, 14, byte-address width of o_mem_addr; PC wraps modulo 2^ADDR_W
- RESET_PC, 0, PC loaded on reset (must be word aligned)
- MEM_LAT, 1, memory read latency in cycles (1..4); read data valid MEM_LAT cycles after the address cycle
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_enable  in  1  when low, all state, PC, regfile and outputs hold
- o_mem_write_en  out  1  one-cycle write strobe
- o_mem_addr  out  ADDR_W  byte address, bits [1:0] always 0
- o_mem_data  out  32  store data, valid with o_mem_write_en
- i_mem_data  in  32  read data
- o_pc  out  ADDR_W  current PC
- o_is_halted  out  1  high in HALT
- o_fault  out  1  illegal-instruction flag (see Configuration)

## Operation
- Subset: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND), EBREAK (0x00100073).
- Unsupported opcodes/funct values are illegal.
- x0 reads 0; writes to x0 discarded. Regfile not cleared by reset (contents X until written).
- All arithmetic is 32-bit modulo. Shift amount is the low 5 bits. Immediates are sign-extended per RV32I.
- Branch/jump targets are truncated to ADDR_W with bits [1:0] forced 0. JALR clears bit 0, then bit 1.
- LW/SW addresses: effective address truncated to ADDR_W, low 2 bits ignored (no misalignment trap).
- States: INIT → FETCH → FETCH_WAIT → DECODE → EXECUTE → {FETCH | MEM → (MEM_WAIT → WB) | HALT}; HALT is terminal until reset.
- INIT: move to FETCH on the first enabled cycle.
- FETCH: o_mem_addr ← PC.
- FETCH_WAIT: held MEM_LAT cycles (counter).
- DECODE: latch instruction from i_mem_data, read rs1/rs2.
- EXECUTE: ALU, rd writeback for non-load, PC ← PC+4 or target. EBREAK → HALT with PC left at EBREAK address. Load/store → MEM.
- MEM: o_mem_addr ← EA. Store: o_mem_write_en=1, o_mem_data=rs2 for exactly this cycle, then PC+4 → FETCH. Load → MEM_WAIT (MEM_LAT cycles) → WB.
- WB: rd ← i_mem_data, PC+4, → FETCH.

## Timing
- Reset values: o_mem_write_en 0, o_mem_addr 0, o_mem_data 0, o_pc RESET_PC, o_is_halted 0, o_fault 0; state INIT.
- Cycles per instruction (i_enable held high):
  - ALU/branch/jump: MEM_LAT+3
  - store: MEM_LAT+4
  - load: 2·MEM_LAT+5
  - EBREAK: MEM_LAT+3 to o_is_halted.
- o_mem_write_en is never high outside MEM.
- Deasserting i_enable mid-wait freezes the latency counter; it resumes without losing data only if memory also holds its output (the memory model guarantees this).
- Reset mid-instruction aborts it. A pending store not yet in MEM is never issued.
- o_is_halted is registered: it rises the cycle after the transition to HALT.

## Configuration
- CPU_ILLEGAL_TRAP_EN defined: an illegal instruction in EXECUTE → HALT with o_fault=1 and PC at the offending instruction.
- Undefined: illegal instructions execute as NOP (PC+4, no register or memory write), and o_fault is tied 0.

## Test plan
- ADDI x1,x0,5; ADDI x2,x1,-7; SW x2,0x100(x0); EBREAK → mem[0x100]=0xFFFFFFFE, halt with o_pc=0xC.
- MEM_LAT=3: LW x3,0x100(x0) after the above preload → x3 = 0xFFFFFFFE in exactly 11 cycles; verify via a following SW.
- Loop `ADDI x1,x1,1; BNE x1,x5,-4` with x5=10 → exits with x1=10.
- JAL x1,+8; JALR x0,0(x1) → x1=PC+4, return lands correctly. Also check PC wrap at 2^ADDR_W−4 → 0.
- i_enable toggled every other cycle during a load → same result, and o_mem_write_en is never a spurious pulse.
- Word 0xFFFFFFFF:
  - with CPU_ILLEGAL_TRAP_EN → o_fault=1, halt at its PC
  - without → skipped, next instruction executes.

Source files
------------

// File: rtl/cpu_rv32_mc.sv
// Multicycle RV32I-subset core driving a single-port synchronous word memory with MEM_LAT read latency.
// Build option: define CPU_ILLEGAL_TRAP_EN to halt with o_fault on illegal instructions (default: NOP).
`timescale 1ns/1ps
module cpu_rv32_mc #(
  parameter int unsigned       ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MEM_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_is_halted,
  output logic              o_fault
);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;
  localparam logic [2:0]  LAT_LAST   = 3'(MEM_LAT - 1);

`ifdef CPU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE, S_MEM, S_MEM_WAIT, S_WB, S_HALT
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, pc_plus4, addr_q, addr_nx;
  logic [31:0]       ir, rs1_v, rs2_v;
  logic [2:0]        cnt;
  logic              halted, wait_done;
  logic [31:0]       regs [32];

  // Decode fields
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1_idx, rs2_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc32;
  logic        legal, is_ebreak, is_load, is_store, writes_rd;

  assign opcode    = ir[6:0];
  assign f3        = ir[14:12];
  assign f7        = ir[31:25];
  assign rd        = ir[11:7];
  assign imm_i     = {{20{ir[31]}}, ir[31:20]};
  assign imm_s     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u     = {ir[31:12], 12'b0};
  assign imm_j     = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc32      = 32'(pc);
  assign pc_plus4  = pc + ADDR_W'(4);
  assign is_ebreak = (ir == EBREAK);
  assign is_load   = (opcode == OPC_LOAD)  && (f3 == 3'd2);
  assign is_store  = (opcode == OPC_STORE) && (f3 == 3'd2);
  assign wait_done = (cnt == LAT_LAST);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (f3 == 3'd0);
      OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
      OPC_LOAD:   legal = is_load;
      OPC_STORE:  legal = is_store;
      OPC_OPIMM:  legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OPC_OP:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OPC_SYSTEM: legal = is_ebreak;
      default:    legal = 1'b0;
    endcase
  end

  assign writes_rd = legal && (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL ||
                               opcode == OPC_JALR || opcode == OPC_OPIMM || opcode == OPC_OP);

  // ALU: register or immediate second operand; ir[30] selects SUB / SRA
  logic [31:0] op_b, alu, rd_data;
  logic [4:0]  shamt;
  assign op_b  = (opcode == OPC_OP) ? rs2_v : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    alu = '0;
    case (f3)
      3'd0: alu = (opcode == OPC_OP && ir[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'd1: alu = rs1_v << shamt;
      3'd2: alu = {31'b0, $signed(rs1_v) < $signed(op_b)};
      3'd3: alu = {31'b0, rs1_v < op_b};
      3'd4: alu = rs1_v ^ op_b;
      3'd5: alu = ir[30] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'd6: alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end

  always_comb begin
    rd_data = alu;
    case (opcode)
      OPC_LUI:           rd_data = imm_u;
      OPC_AUIPC:         rd_data = pc32 + imm_u;
      OPC_JAL, OPC_JALR: rd_data = 32'(pc_plus4);
      default:           rd_data = alu;
    endcase
  end

  // Targets and effective address, truncated to ADDR_W with the low two bits dropped
  logic [31:0]       br_tgt, jal_tgt, jalr_tgt, ea;
  logic [ADDR_W-1:0] br_pc, jal_pc, jalr_pc, ea_addr;
  logic              br_base, br_taken, unused_bits;
  assign br_tgt   = pc32 + imm_b;
  assign jal_tgt  = pc32 + imm_j;
  assign jalr_tgt = rs1_v + imm_i;
  assign ea       = rs1_v + (is_store ? imm_s : imm_i);
  assign br_pc    = {br_tgt[ADDR_W-1:2], 2'b00};
  assign jal_pc   = {jal_tgt[ADDR_W-1:2], 2'b00};
  assign jalr_pc  = {jalr_tgt[ADDR_W-1:2], 2'b00};
  assign ea_addr  = {ea[ADDR_W-1:2], 2'b00};
  assign unused_bits = ^{br_tgt, jal_tgt, jalr_tgt, ea};

  always_comb begin
    br_base  = f3[2] ? (f3[1] ? (rs1_v < rs2_v) : ($signed(rs1_v) < $signed(rs2_v)))
                     : (rs1_v == rs2_v);
    br_taken = br_base ^ f3[0];
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst)         state <= S_INIT;
    else if (i_enable) state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:       state_nx = S_FETCH;
      S_FETCH:      state_nx = S_FETCH_WAIT;
      S_FETCH_WAIT: if (wait_done) state_nx = S_DECODE;
      S_DECODE:     state_nx = S_EXECUTE;
      S_EXECUTE: begin
        if (is_ebreak || (TRAP_EN && !legal)) state_nx = S_HALT;
        else if (is_load || is_store)         state_nx = S_MEM;
        else                                  state_nx = S_FETCH;
      end
      S_MEM:        state_nx = is_store ? S_FETCH : S_MEM_WAIT;
      S_MEM_WAIT:   if (wait_done) state_nx = S_WB;
      S_WB:         state_nx = S_FETCH;
      default:      state_nx = S_HALT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_mem_write_en = 1'b0;
    o_mem_data     = '0;
    if (state == S_MEM && is_store) begin
      o_mem_write_en = 1'b1;
      o_mem_data     = rs2_v;
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_pc        = pc;
  assign o_is_halted = halted;

  always_comb begin
    pc_nx = pc;
    case (state)
      S_EXECUTE: begin
        if (is_ebreak)                   pc_nx = pc;
        else if (!legal)                 pc_nx = TRAP_EN ? pc : pc_plus4;
        else if (opcode == OPC_JAL)      pc_nx = jal_pc;
        else if (opcode == OPC_JALR)     pc_nx = jalr_pc;
        else if (opcode == OPC_BRANCH)   pc_nx = br_taken ? br_pc : pc_plus4;
        else if (!(is_load || is_store)) pc_nx = pc_plus4;
      end
      S_MEM:   if (is_store) pc_nx = pc_plus4;
      S_WB:    pc_nx = pc_plus4;
      default: pc_nx = pc;
    endcase
  end

  // Address is held between FETCH/MEM so the memory keeps presenting the same word during waits
  always_comb begin
    addr_nx = addr_q;
    if (state_nx == S_FETCH)    addr_nx = pc_nx;
    else if (state_nx == S_MEM) addr_nx = ea_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc     <= RESET_PC;
      addr_q <= '0;
      cnt    <= '0;
      halted <= 1'b0;
      ir     <= '0;
      rs1_v  <= '0;
      rs2_v  <= '0;
    end else if (i_enable) begin
      pc     <= pc_nx;
      addr_q <= addr_nx;
      halted <= (state_nx == S_HALT);
      if ((state == S_FETCH_WAIT || state == S_MEM_WAIT) && !wait_done) cnt <= cnt + 3'd1;
      else                                                              cnt <= '0;
      if (state == S_DECODE) begin
        ir    <= i_mem_data;
        rs1_v <= (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
        rs2_v <= (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];
      end
    end
  end

  assign rs1_idx = i_mem_data[19:15];
  assign rs2_idx = i_mem_data[24:20];

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_enable && rd != 5'd0) begin
      if (state == S_EXECUTE && writes_rd) regs[rd] <= rd_data;
      else if (state == S_WB)              regs[rd] <= i_mem_data;
    end
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  logic fault_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) fault_q <= 1'b0;
    else if (i_enable && state == S_EXECUTE && !legal) fault_q <= 1'b1;
  end
  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_rv32_mc.sv
// Directed bench for cpu_rv32_mc (MEM_LAT=3) with a latency-pipelined word memory model.
`timescale 1ns/1ps
module tb_cpu_rv32_mc;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic        we, halted, fault;
  logic [13:0] addr, pc;
  logic [31:0] wdata, rdata;
  logic [31:0] mem  [4096];
  logic [31:0] pipe [3];
  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  cpu_rv32_mc #(.ADDR_W(14), .RESET_PC(14'h0), .MEM_LAT(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .o_mem_write_en(we), .o_mem_addr(addr), .o_mem_data(wdata), .i_mem_data(rdata),
    .o_pc(pc), .o_is_halted(halted), .o_fault(fault)
  );

  // Read is sampled before the write of the same edge; data appears three cycles after the address
  always @(posedge clk) begin
    pipe[0] <= mem[addr[13:2]];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    if (we) mem[addr[13:2]] = wdata;
  end
  assign rdata = pipe[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(7'h13, 3'd0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(7'h03, 3'd2, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(7'h67, 3'd0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] bne(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm20);
    return {imm20, rd, 7'h37};
  endfunction

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (!halted && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_halt"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int cyc, wcnt, bad;

    // Reset values
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",     32'(we),     32'd0);
    check("rst_addr",   32'(addr),   32'd0);
    check("rst_wdata",  wdata,       32'd0);
    check("rst_pc",     32'(pc),     32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault",  32'(fault),  32'd0);

    // ADDI/ADDI/SW/EBREAK: 6+6+7+6 cycles after the INIT cycle
    clear_mem();
    mem[0] = addi(5'd1, 5'd0, 5);
    mem[1] = addi(5'd2, 5'd1, -7);
    mem[2] = sw(5'd2, 5'd0, 32'h100);
    mem[3] = EBREAK;
    do_reset();
    wait_halt("t1", 200, cyc);
    check("t1_cycles", 32'(cyc), 32'd26);
    check("t1_mem",    mem[32'h40], 32'hFFFF_FFFE);
    check("t1_pc",     32'(pc), 32'h00C);
    check("t1_fault",  32'(fault), 32'd0);

    // LW takes 2*3+5 = 11 cycles; pc reaches 4 on edge 12 counting the INIT edge
    clear_mem();
    mem[32'h40] = 32'hFFFF_FFFE;
    mem[0] = lw(5'd3, 5'd0, 32'h100);
    mem[1] = sw(5'd3, 5'd0, 32'h104);
    mem[2] = EBREAK;
    do_reset();
    cyc = 0;
    while (pc != 14'h4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("lw_cycles", 32'(cyc), 32'd12);
    wait_halt("lw", 200, cyc);
    check("lw_mem", mem[32'h41], 32'hFFFF_FFFE);

    // Counting loop until x1 == x5 == 10
    clear_mem();
    mem[0] = addi(5'd5, 5'd0, 10);
    mem[1] = addi(5'd1, 5'd0, 0);
    mem[2] = addi(5'd1, 5'd1, 1);
    mem[3] = bne(5'd1, 5'd5, -4);
    mem[4] = sw(5'd1, 5'd0, 32'h100);
    mem[5] = EBREAK;
    do_reset();
    wait_halt("loop", 2000, cyc);
    check("loop_x1", mem[32'h40], 32'd10);
    check("loop_pc", 32'(pc), 32'h014);

    // JAL x1,+12 ; JALR x0,3(x1) -> (4+3) with bits 1:0 cleared = 4
    clear_mem();
    mem[0] = jal(5'd1, 12);
    mem[1] = sw(5'd1, 5'd0, 32'h100);
    mem[2] = EBREAK;
    mem[3] = jalr(5'd0, 5'd1, 3);
    do_reset();
    wait_halt("jal", 300, cyc);
    check("jal_link", mem[32'h40], 32'd4);
    check("jal_pc",   32'(pc), 32'h008);

    // Sequential PC wrap from 0x3FFC to 0, with a memory flag to take a different path second time
    clear_mem();
    mem[0]     = lw(5'd6, 5'd0, 32'h100);
    mem[1]     = bne(5'd6, 5'd0, 16);
    mem[2]     = addi(5'd6, 5'd0, 1);
    mem[3]     = sw(5'd6, 5'd0, 32'h100);
    mem[4]     = jal(5'd0, 32'h3FEC);
    mem[5]     = sw(5'd7, 5'd0, 32'h104);
    mem[6]     = EBREAK;
    mem[12'hFFF] = addi(5'd7, 5'd0, 9);
    do_reset();
    wait_halt("wrap", 500, cyc);
    check("wrap_x7", mem[32'h41], 32'd9);
    check("wrap_pc", 32'(pc), 32'h018);

    // Register ALU ops and LUI/XORI
    clear_mem();
    mem[0]  = addi(5'd1, 5'd0, -16);
    mem[1]  = addi(5'd2, 5'd0, 3);
    mem[2]  = enc_r(7'h20, 3'd5, 5'd3, 5'd1, 5'd2);
    mem[3]  = sw(5'd3, 5'd0, 32'h100);
    mem[4]  = enc_r(7'h20, 3'd0, 5'd4, 5'd2, 5'd1);
    mem[5]  = sw(5'd4, 5'd0, 32'h104);
    mem[6]  = enc_r(7'h00, 3'd3, 5'd5, 5'd2, 5'd1);
    mem[7]  = sw(5'd5, 5'd0, 32'h108);
    mem[8]  = enc_r(7'h00, 3'd5, 5'd6, 5'd1, 5'd2);
    mem[9]  = sw(5'd6, 5'd0, 32'h10C);
    mem[10] = lui(5'd7, 20'h12345);
    mem[11] = enc_i(7'h13, 3'd4, 5'd7, 5'd7, 32'h0FF);
    mem[12] = sw(5'd7, 5'd0, 32'h110);
    mem[13] = EBREAK;
    do_reset();
    wait_halt("alu", 500, cyc);
    check("alu_sra",  mem[32'h40], 32'hFFFF_FFFE);
    check("alu_sub",  mem[32'h41], 32'd19);
    check("alu_sltu", mem[32'h42], 32'd1);
    check("alu_srl",  mem[32'h43], 32'h1FFF_FFFE);
    check("alu_lui",  mem[32'h44], 32'h1234_50FF);

    // Enable toggled every cycle across a load and a store
    clear_mem();
    mem[32'h40] = 32'hFFFF_FFFE;
    mem[0] = lw(5'd3, 5'd0, 32'h100);
    mem[1] = sw(5'd3, 5'd0, 32'h104);
    mem[2] = EBREAK;
    do_reset();
    wcnt = 0;
    bad  = 0;
    cyc  = 0;
    while (!halted && cyc < 400) begin
      @(negedge clk);
      if (we && en) wcnt++;
      if (we && addr != 14'h104) bad++;
      @(posedge clk);
      #1;
      en = ~en;
      cyc++;
    end
    en = 1'b1;
    check("tog_halt",   32'(halted), 32'd1);
    check("tog_writes", 32'(wcnt), 32'd1);
    check("tog_stray",  32'(bad), 32'd0);
    check("tog_mem",    mem[32'h41], 32'hFFFF_FFFE);

    // Illegal word 0xFFFFFFFF
    clear_mem();
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = addi(5'd1, 5'd0, 3);
    mem[2] = sw(5'd1, 5'd0, 32'h100);
    mem[3] = EBREAK;
    do_reset();
    wait_halt("ill", 300, cyc);
`ifdef CPU_ILLEGAL_TRAP_EN
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_pc",    32'(pc), 32'h000);
    check("ill_mem",   mem[32'h40], 32'd0);
`else
    check("ill_fault", 32'(fault), 32'd0);
    check("ill_pc",    32'(pc), 32'h00C);
    check("ill_mem",   mem[32'h40], 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
